pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the CPU fetch stage. It holds the fetch PC and selects the next PC from the sequential, branch, jump, register-jump, exception and exception-return sources. It supports pipeline stall with a one-entry pending-redirect buffer, records the exception PC (EPC), and traps misaligned redirect targets. All outputs are always driven; there is no tri-state.

## Interface
- ADDR_W, 32, PC/address width
- RESET_VEC, 32'h0040_0000, PC value after reset
- EXC_VEC, 32'h0040_0004, exception handler entry address
- INC, 4, sequential increment in bytes
- ALIGN_BITS, 2, low target bits that must be zero
- pc_clk  in  1  clock; all state updates on the falling edge
- rst_n  in  1  asynchronous, active-low reset
- pc_ena  in  1  global enable; low = hold all state, ignore all requests
- stall  in  1  fetch stall; PC holds
- br_taken  in  1  conditional branch taken
- br_target  in  ADDR_W  branch target
- jmp  in  1  direct jump
- jmp_target  in  ADDR_W  jump target
- jr  in  1  register jump
- jr_target  in  ADDR_W  register jump target
- exc  in  1  exception request
- eret  in  1  return from exception
- pc_out  out  ADDR_W  current fetch PC
- pc_plus  out  ADDR_W  pc_out + INC, combinational
- epc_out  out  ADDR_W  saved exception PC
- addr_err  out  1  one-cycle pulse: a misaligned target was trapped
- redir_pend  out  1  pending-redirect buffer occupied

## Operation
- Reset (rst_n low, asynchronous): pc_out=RESET_VEC, epc_out=0, addr_err=0, redir_pend=0, buffer target=0.
- Source priority per edge: exc > eret > pending buffer > jr > jmp > br_taken > sequential (pc_out+INC).
- exc: PC←EXC_VEC, EPC←pc_out, buffer cleared. Exceptions ignore stall.
- eret: PC←EPC. Stall blocks eret; it is buffered like any other redirect.
- Stall high, no exc: PC holds.
  - Any jr/jmp/br_taken/eret is written into the buffer (target resolved at capture; eret captures current EPC), and redir_pend=1.
  - If the buffer is already full, it keeps its contents: the oldest redirect wins.
- Stall low, buffer full: PC←buffered target, buffer cleared. Same-edge jr/jmp/br requests are dropped.
- Misalignment: a selected jr/jmp/br/buffered target with any of the low ALIGN_BITS bits set is not loaded.
  - Instead: PC←EXC_VEC, EPC←offending target, addr_err=1 for exactly one cycle, buffer cleared.
  - Sequential, EXC_VEC and eret targets are never checked.
- Arithmetic: pc_out+INC is unsigned, modulo 2^ADDR_W; wrap-around is silent.
- pc_ena low: every register holds, addr_err is forced low, and all inputs (including exc) are ignored.

## Timing
- Next-PC selection is combinational from the inputs and current state; registers load on the falling edge of pc_clk.
- Redirect latency: request present before a falling edge → pc_out equals the target after that edge (zero added cycles).
- Buffered redirect: emitted on the first falling edge with stall low.
- addr_err: asserted after the trapping edge, cleared after the next edge.
- rst_n deassertion is synchronised externally; the first update is on the first falling edge with rst_n high.
- Reset mid-stall: buffer is lost, PC returns to RESET_VEC.

## Structure
- Package pc_pkg holds:
  - next-PC source select constants (SRC_SEQ, SRC_BR, SRC_JMP, SRC_JR, SRC_BUF, SRC_ERET, SRC_EXC)
  - default RESET_VEC/EXC_VEC values
  - the alignment-check function
- Sub-module pc_redirect_buf: one-entry capture/hold/clear register holding target and valid bit, with the oldest-wins rule.
- Priority mux, EPC register and PC register live in pc_unit.

## Test plan
- Reset then 3 enabled edges, no requests → pc_out 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; epc_out=0.
- At PC 0x0040_0010, jmp=1 (0x0040_0100) and br_taken=1 (0x0040_0200) on the same edge → pc_out=0x0040_0100.
- Stall high 3 edges; jr=1 (0x0040_0300) on the 1st, jmp=1 (0x0040_0400) on the 2nd → PC holds, redir_pend=1; stall low → pc_out=0x0040_0300, redir_pend=0.
- At PC 0x0040_0020, br_taken with target 0x0040_0102 → pc_out=0x0040_0004, epc_out=0x0040_0102, addr_err high for one cycle only.
- exc at PC 0x0040_0050 while stalled with a buffered redirect → pc_out=0x0040_0004, epc_out=0x0040_0050, redir_pend=0; later eret → pc_out=0x0040_0050.
- pc_ena low with exc=1 → no state change; PC 0xFFFF_FFFC sequential step → pc_out=0x0000_0000; rst_n low mid-stall → immediate pc_out=0x0040_0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter unit: next-PC source codes,
// default vectors and the target alignment check.
package pc_pkg;

    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_JMP  = 3'd2;
    localparam logic [2:0] SRC_JR   = 3'd3;
    localparam logic [2:0] SRC_BUF  = 3'd4;
    localparam logic [2:0] SRC_ERET = 3'd5;
    localparam logic [2:0] SRC_EXC  = 3'd6;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0004;

    // True when any of the lowest nbits address bits is set.
    function automatic logic misaligned(input logic [63:0] addr, input int unsigned nbits);
        logic m;
        m = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(nbits)) begin
                m = m | addr[i];
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer; a held entry is never overwritten, so the
// oldest redirect captured during a stall is the one later replayed.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              capture,
    input  logic [ADDR_W-1:0] capture_target,
    input  logic              clear,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    logic              valid_r;
    logic [ADDR_W-1:0] target_r;

    // Capture when empty, clear on consume/exception/trap, otherwise hold.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            target_r <= '0;
        end else if (!ena) begin
            valid_r  <= valid_r;
            target_r <= target_r;
        end else if (clear) begin
            valid_r  <= 1'b0;
            target_r <= '0;
        end else if (capture && !valid_r) begin
            valid_r  <= 1'b1;
            target_r <= capture_target;
        end else begin
            valid_r  <= valid_r;
            target_r <= target_r;
        end
    end

    assign valid  = valid_r;
    assign target = target_r;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: prioritised next-PC selection, stall with one pending
// redirect, exception PC capture and misaligned-target trapping.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
    parameter int                INC        = 4,
    parameter int unsigned       ALIGN_BITS = 2
) (
    input  logic              pc_clk,
    input  logic              rst_n,
    input  logic              pc_ena,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] epc_out,
    output logic              addr_err,
    output logic              redir_pend
);

    logic [ADDR_W-1:0] pc_r, epc_r, pc_plus_s;
    logic              addr_err_r;
    logic [2:0]        src_s;
    logic              hold_s, cap_s, check_s, buf_clear_s, buf_valid_s, addr_err_next_s;
    logic [ADDR_W-1:0] cap_target_s, buf_target_s, target_s, pc_next_s, epc_next_s;

    assign pc_plus_s = pc_r + ADDR_W'(INC);

    // Source selection; while stalled the highest-priority redirect is offered to the buffer.
    always_comb begin
        src_s        = SRC_SEQ;
        hold_s       = 1'b0;
        cap_s        = 1'b0;
        cap_target_s = br_target;
        if (exc) begin
            src_s = SRC_EXC;
        end else if (stall) begin
            hold_s = 1'b1;
            cap_s  = eret | jr | jmp | br_taken;
            if (eret) begin
                cap_target_s = epc_r;
            end else if (jr) begin
                cap_target_s = jr_target;
            end else if (jmp) begin
                cap_target_s = jmp_target;
            end else begin
                cap_target_s = br_target;
            end
        end else if (eret) begin
            src_s = SRC_ERET;
        end else if (buf_valid_s) begin
            src_s = SRC_BUF;
        end else if (jr) begin
            src_s = SRC_JR;
        end else if (jmp) begin
            src_s = SRC_JMP;
        end else if (br_taken) begin
            src_s = SRC_BR;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Target mux and next-state for PC, EPC, trap pulse and buffer clear.
    always_comb begin
        target_s        = pc_plus_s;
        check_s         = 1'b0;
        pc_next_s       = pc_r;
        epc_next_s      = epc_r;
        addr_err_next_s = 1'b0;
        buf_clear_s     = 1'b0;
        case (src_s)
            SRC_ERET: target_s = epc_r;
            SRC_BUF:  begin target_s = buf_target_s; check_s = 1'b1; end
            SRC_JR:   begin target_s = jr_target;    check_s = 1'b1; end
            SRC_JMP:  begin target_s = jmp_target;   check_s = 1'b1; end
            SRC_BR:   begin target_s = br_target;    check_s = 1'b1; end
            SRC_EXC:  target_s = EXC_VEC;
            default:  target_s = pc_plus_s;
        endcase
        if (hold_s) begin
            pc_next_s = pc_r;
        end else if (src_s == SRC_EXC) begin
            pc_next_s   = EXC_VEC;
            epc_next_s  = pc_r;
            buf_clear_s = 1'b1;
        end else if (check_s && misaligned(64'(target_s), ALIGN_BITS)) begin
            pc_next_s       = EXC_VEC;
            epc_next_s      = target_s;
            addr_err_next_s = 1'b1;
            buf_clear_s     = 1'b1;
        end else begin
            pc_next_s   = target_s;
            buf_clear_s = (src_s == SRC_BUF);
        end
    end

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk            (pc_clk),
        .rst_n          (rst_n),
        .ena            (pc_ena),
        .capture        (cap_s),
        .capture_target (cap_target_s),
        .clear          (buf_clear_s),
        .valid          (buf_valid_s),
        .target         (buf_target_s)
    );

    // PC, EPC and trap-pulse registers; disabled edges hold state and drop the pulse.
    always_ff @(negedge pc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_VEC;
            epc_r      <= '0;
            addr_err_r <= 1'b0;
        end else if (pc_ena) begin
            pc_r       <= pc_next_s;
            epc_r      <= epc_next_s;
            addr_err_r <= addr_err_next_s;
        end else begin
            pc_r       <= pc_r;
            epc_r      <= epc_r;
            addr_err_r <= 1'b0;
        end
    end

    assign pc_out     = pc_r;
    assign pc_plus    = pc_plus_s;
    assign epc_out    = epc_r;
    assign addr_err   = addr_err_r;
    assign redir_pend = buf_valid_s;

endmodule
